// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter and sequencer for the single-ported Y86 ram.
// Build option: define MEM_ARB_RR_EN for round-robin instead of fixed data priority.

`ifndef ADDR_BUS
`define ADDR_BUS 63:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 63:0
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 1023
`endif

module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_req_i,
  input  logic [`ADDR_BUS] if_addr_i,
  output logic             if_gnt_o,
  output logic             if_rvalid_o,
  output logic [`DATA_BUS] if_rdata_o,
  output logic             if_err_o,
  input  logic             d_req_i,
  input  logic             d_we_i,
  input  logic [`ADDR_BUS] d_addr_i,
  input  logic [`DATA_BUS] d_wdata_i,
  output logic             d_gnt_o,
  output logic             d_rvalid_o,
  output logic [`DATA_BUS] d_rdata_o,
  output logic             d_err_o,
  output logic             ram_r_en_o,
  output logic             ram_w_en_o,
  output logic [`ADDR_BUS] ram_addr_o,
  output logic [`DATA_BUS] ram_wdata_o,
  input  logic [`DATA_BUS] ram_rdata_i,
  input  logic             ram_err_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  state_t             state;
  logic               owner_q;
  logic               we_q;
  logic [`ADDR_BUS]   addr_q;
  logic [`DATA_BUS]   wdata_q;
  logic               arb_en;
  logic               grant_d;
  logic               grant_if;
  logic               in_access;
  logic [`DATA_BUS]   rdata_c;

  // Arbitration only in IDLE/RESP and never while reset is held.
  assign arb_en = !rst_i && ((state == IDLE) || (state == RESP));

`ifdef MEM_ARB_RR_EN
  logic last_owner;

  // Round-robin: a tie goes to the port that did not win last time.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (arb_en) begin
      if (d_req_i && if_req_i) begin
        grant_d  = (last_owner == PORT_IF);
        grant_if = (last_owner == PORT_D);
      end else begin
        grant_d  = d_req_i;
        grant_if = if_req_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         last_owner <= PORT_IF;
    else if (grant_d)  last_owner <= PORT_D;
    else if (grant_if) last_owner <= PORT_IF;
  end
`else
  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  // Data wins unless fetch has waited through STARVE_LIMIT data grants.
  assign starved = if_req_i && (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant_d  = arb_en && d_req_i && !starved;
    grant_if = arb_en && if_req_i && !grant_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !if_req_i || grant_if) starve_cnt <= '0;
    else if (grant_d)                   starve_cnt <= starve_cnt + CNT_W'(1);
  end
`endif

  assign if_gnt_o = grant_if;
  assign d_gnt_o  = grant_d;

  // RAM is driven only during ACCESS; a write is also killed by an address error or reset.
  assign in_access   = (state == ACCESS) && !rst_i;
  assign ram_r_en_o  = in_access && !we_q;
  assign ram_w_en_o  = in_access && we_q && !ram_err_i;
  assign ram_addr_o  = in_access ? addr_q  : '0;
  assign ram_wdata_o = in_access ? wdata_q : '0;
  assign rdata_c     = (we_q || ram_err_i) ? '0 : ram_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      owner_q     <= PORT_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      if_err_o    <= 1'b0;
      d_rvalid_o  <= 1'b0;
      d_rdata_o   <= '0;
      d_err_o     <= 1'b0;
    end else begin
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      if_err_o    <= 1'b0;
      d_rvalid_o  <= 1'b0;
      d_rdata_o   <= '0;
      d_err_o     <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (grant_d || grant_if) begin
            state   <= ACCESS;
            owner_q <= grant_d ? PORT_D : PORT_IF;
            we_q    <= grant_d && d_we_i;
            addr_q  <= grant_d ? d_addr_i : if_addr_i;
            wdata_q <= grant_d ? d_wdata_i : '0;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (owner_q == PORT_D) begin
            d_rvalid_o <= 1'b1;
            d_rdata_o  <= rdata_c;
            d_err_o    <= ram_err_i;
          end else begin
            if_rvalid_o <= 1'b1;
            if_rdata_o  <= rdata_c;
            if_err_o    <= ram_err_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, response scoreboard, vector table and corner sequences.
`timescale 1ns/1ps

`ifndef ADDR_BUS
`define ADDR_BUS 63:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 63:0
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 1023
`endif

module tb_mem_arbiter;

  localparam logic [63:0] MEM_MAX = 64'(`MEM_SIZE);

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             if_req_i = 1'b0;
  logic [`ADDR_BUS] if_addr_i = '0;
  logic             if_gnt_o, if_rvalid_o, if_err_o;
  logic [`DATA_BUS] if_rdata_o;
  logic             d_req_i = 1'b0;
  logic             d_we_i = 1'b0;
  logic [`ADDR_BUS] d_addr_i = '0;
  logic [`DATA_BUS] d_wdata_i = '0;
  logic             d_gnt_o, d_rvalid_o, d_err_o;
  logic [`DATA_BUS] d_rdata_o;
  logic             ram_r_en_o, ram_w_en_o, ram_err_i;
  logic [`ADDR_BUS] ram_addr_o;
  logic [`DATA_BUS] ram_wdata_o, ram_rdata_i;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .ram_r_en_o(ram_r_en_o), .ram_w_en_o(ram_w_en_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_err_i(ram_err_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: combinational read and error, write on the rising edge.
  logic [63:0] mem [0:`MEM_SIZE];
  assign ram_err_i   = (ram_addr_o > MEM_MAX);
  assign ram_rdata_i = ram_err_i ? 64'd0 : mem[ram_addr_o[9:0]];
  always @(posedge clk_i) if (ram_w_en_o) mem[ram_addr_o[9:0]] <= ram_wdata_o;

  typedef struct {
    bit          is_d;
    logic [63:0] rdata;
    bit          err;
  } resp_t;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    bit          exp_err;
    int          exp_wr;
  } vec_t;

  resp_t sb[$];
  resp_t mon_e;
  int    checks = 0;
  int    errors = 0;
  int    wcount = 0;

  // Response monitor: every rvalid pulse must match the oldest expected response.
  initial forever begin
    @(negedge clk_i);
    if (ram_w_en_o) wcount++;
    if (!rst_i && (if_rvalid_o || d_rvalid_o)) begin
      checks++;
      if (if_rvalid_o && d_rvalid_o) begin
        errors++;
        $display("FAIL both_rvalid t=%0t: if_rvalid=1 d_rvalid=1, required one", $time);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid t=%0t: if=%0b d=%0b with nothing pending",
                 $time, if_rvalid_o, d_rvalid_o);
      end else begin
        mon_e = sb.pop_front();
        if ((d_rvalid_o != mon_e.is_d) ||
            ((d_rvalid_o ? d_rdata_o : if_rdata_o) != mon_e.rdata) ||
            ((d_rvalid_o ? d_err_o : if_err_o) != mon_e.err) ||
            ((d_rvalid_o ? if_rdata_o : d_rdata_o) != 64'd0) ||
            ((d_rvalid_o ? if_err_o : d_err_o) != 1'b0)) begin
          errors++;
          $display("FAIL resp t=%0t: got port_d=%0b rdata=%h err=%0b, required port_d=%0b rdata=%h err=%0b",
                   $time, d_rvalid_o, d_rvalid_o ? d_rdata_o : if_rdata_o,
                   d_rvalid_o ? d_err_o : if_err_o, mon_e.is_d, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  // Raise a request, wait (bounded) for its grant, queue its expected response, then release it.
  task automatic do_access(input bit is_d, input bit we, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] exp_rdata,
                           input bit exp_err);
    int n = 0;
    resp_t e;
    @(negedge clk_i);
    if (is_d) begin
      d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    #1;
    while (!(is_d ? d_gnt_o : if_gnt_o) && n < 20) begin
      @(negedge clk_i); #1; n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: port_d=%0b addr=%h never granted", is_d, addr);
    end else begin
      e.is_d = is_d; e.rdata = exp_rdata; e.err = exp_err;
      sb.push_back(e);
    end
    @(posedge clk_i); #1;
    if (is_d) d_req_i = 1'b0; else if_req_i = 1'b0;
  endtask

  vec_t  vecs[11];
  resp_t e0;
  string exp_seq;
  int    w0, ng, cyc;
  byte   got;

  initial begin
    for (int i = 0; i <= `MEM_SIZE; i++) mem[i] = 64'd0;
    mem[16] = 64'h1122334455667788;

    vecs[0]  = '{1'b1, 1'b1, 64'h20,        64'hDEADBEEF,          64'd0,                 1'b0, 1};
    vecs[1]  = '{1'b1, 1'b0, 64'h20,        64'd0,                 64'hDEADBEEF,          1'b0, 0};
    vecs[2]  = '{1'b0, 1'b0, 64'h10,        64'd0,                 64'h1122334455667788,  1'b0, 0};
    vecs[3]  = '{1'b1, 1'b1, MEM_MAX + 1,   64'h55,                64'd0,                 1'b1, 0};
    vecs[4]  = '{1'b1, 1'b0, MEM_MAX + 1,   64'd0,                 64'd0,                 1'b1, 0};
    vecs[5]  = '{1'b1, 1'b1, MEM_MAX,       64'h0BADF00D,          64'd0,                 1'b0, 1};
    vecs[6]  = '{1'b1, 1'b0, MEM_MAX,       64'd0,                 64'h0BADF00D,          1'b0, 0};
    vecs[7]  = '{1'b0, 1'b0, 64'h20,        64'd0,                 64'hDEADBEEF,          1'b0, 0};
    vecs[8]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0,       64'd0,                 1'b1, 0};
    vecs[9]  = '{1'b1, 1'b1, 64'h30,        64'h0123456789ABCDEF,  64'd0,                 1'b0, 1};
    vecs[10] = '{1'b0, 1'b0, 64'h30,        64'd0,                 64'h0123456789ABCDEF,  1'b0, 0};

    // Reset held with both requests up: everything stays quiet.
    if_req_i = 1'b1; if_addr_i = 64'h10;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h60; d_wdata_i = 64'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if ({if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, if_err_o, d_err_o,
           ram_r_en_o, ram_w_en_o} != 8'd0 || if_rdata_o != 64'd0 || d_rdata_o != 64'd0 ||
          ram_addr_o != 64'd0 || ram_wdata_o != 64'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: gnt=%0b%0b rvalid=%0b%0b ren=%0b wen=%0b, required all 0",
                 i, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, ram_r_en_o, ram_w_en_o);
      end
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL first_gnt: d_gnt=%0b if_gnt=%0b, required d_gnt=1 if_gnt=0", d_gnt_o, if_gnt_o);
    end else begin
      e0.is_d = 1'b1; e0.rdata = 64'd0; e0.err = 1'b0;
      sb.push_back(e0);
    end
    @(posedge clk_i); #1;
    d_req_i = 1'b0; if_req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (mem[96] != 64'h99) begin
      errors++;
      $display("FAIL reset_release_write: mem[0x60]=%h, required 99", mem[96]);
    end

    // Single fetch latency: gnt at N, RAM read at N+1, rvalid at N+2.
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 64'h10;
    #1;
    checks++;
    if (if_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL fetch_gnt: if_gnt=%0b, required 1", if_gnt_o);
    end
    e0.is_d = 1'b0; e0.rdata = 64'h1122334455667788; e0.err = 1'b0;
    sb.push_back(e0);
    @(posedge clk_i); #1;
    if_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (ram_r_en_o !== 1'b1 || ram_w_en_o !== 1'b0 || ram_addr_o != 64'h10) begin
      errors++;
      $display("FAIL fetch_access: ren=%0b wen=%0b addr=%h, required ren=1 wen=0 addr=10",
               ram_r_en_o, ram_w_en_o, ram_addr_o);
    end
    @(negedge clk_i);
    checks++;
    if (if_rvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL fetch_rvalid_latency: if_rvalid=%0b at N+2, required 1", if_rvalid_o);
    end

    // Vector table: one access at a time, write-enable count checked per access.
    foreach (vecs[i]) begin
      w0 = wcount;
      do_access(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_err);
      @(negedge clk_i); @(negedge clk_i); #1;
      checks++;
      if (wcount - w0 != vecs[i].exp_wr) begin
        errors++;
        $display("FAIL vec%0d_wen_count: got %0d write cycles, required %0d",
                 i, wcount - w0, vecs[i].exp_wr);
      end
    end

    // Both requests held: grant order shows the priority policy.
`ifdef MEM_ARB_RR_EN
    exp_seq = "DFDFDFDFDF";
`else
    exp_seq = "DDDDFDDDDF";
`endif
    ng = 0; cyc = 0;
    @(negedge clk_i);
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h20;
    if_req_i = 1'b1; if_addr_i = 64'h10;
    while (ng < 10 && cyc < 100) begin
      #1;
      if (d_gnt_o || if_gnt_o) begin
        got = d_gnt_o ? 8'h44 : 8'h46;
        checks++;
        if ((d_gnt_o && if_gnt_o) || got != exp_seq[ng]) begin
          errors++;
          $display("FAIL arb_seq[%0d]: got d_gnt=%0b if_gnt=%0b, required %s",
                   ng, d_gnt_o, if_gnt_o, (exp_seq[ng] == 8'h44) ? "D" : "F");
        end
        e0.is_d = d_gnt_o;
        e0.rdata = d_gnt_o ? 64'hDEADBEEF : 64'h1122334455667788;
        e0.err = 1'b0;
        sb.push_back(e0);
        ng++;
      end
      if (ng == 10) begin
        @(posedge clk_i); #1;
        d_req_i = 1'b0; if_req_i = 1'b0;
      end else begin
        @(negedge clk_i);
      end
      cyc++;
    end
    if (ng < 10) begin
      checks++; errors++;
      $display("FAIL arb_timeout: got %0d grants, required 10", ng);
    end
    repeat (3) @(negedge clk_i);

    // Write immediately followed by a read of the same address in RESP.
    do_access(1'b1, 1'b1, 64'h50, 64'hFEEDFACE, 64'd0, 1'b0);
    do_access(1'b1, 1'b0, 64'h50, 64'd0, 64'hFEEDFACE, 1'b0);
    repeat (3) @(negedge clk_i);

    // Fetch request raised and withdrawn during ACCESS: no grant, no response.
    do_access(1'b1, 1'b0, 64'h10, 64'd0, 64'h1122334455667788, 1'b0);
    if_req_i = 1'b1; if_addr_i = 64'h30;
    @(negedge clk_i); #1;
    checks++;
    if (if_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL gnt_in_access: if_gnt=%0b, required 0", if_gnt_o);
    end
    #1 if_req_i = 1'b0;
    repeat (4) @(negedge clk_i);

    // Reset during the ACCESS cycle of a write.
    w0 = wcount;
    @(negedge clk_i);
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h40; d_wdata_i = 64'h77;
    #1;
    checks++;
    if (d_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_wr_gnt: d_gnt=%0b, required 1", d_gnt_o);
    end
    @(posedge clk_i); #1;
    d_req_i = 1'b0; rst_i = 1'b1;
    #1;
    checks++;
    if (ram_w_en_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_wen_forced: ram_w_en=%0b during reset, required 0", ram_w_en_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (wcount != w0 || mem[64] != 64'd0) begin
      errors++;
      $display("FAIL rst_wr_suppressed: writes=%0d mem[0x40]=%h, required 0 and 0",
               wcount - w0, mem[64]);
    end
    @(negedge clk_i);
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h40;
    #1;
    checks++;
    if (d_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_back_to_idle: d_gnt=%0b, required immediate 1", d_gnt_o);
    end else begin
      e0.is_d = 1'b1; e0.rdata = 64'd0; e0.err = 1'b0;
      sb.push_back(e0);
    end
    @(posedge clk_i); #1;
    d_req_i = 1'b0;
    repeat (5) @(negedge clk_i);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses still pending, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
